decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 14 +
 rtl/decode_scoreboard.sv | 52 +++++
 rtl/decode_stage.sv | 130 +++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared parameters for the decode stage: default widths and opcode-field
// constants (ALU flag bit position, aluop width).
package decode_pkg;

  localparam int WORD_W  = 16;
  localparam int NIB_W   = 4;
  localparam int ALUOP_W = 3;

  // The ALU flag is the opcode MSB; when it is clear the op is an ALU op.
  function automatic int alu_flag_bit(input int nib_w);
    return nib_w - 1;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Pending-write bitmap: hazard check on the incoming instruction, set of
// the destination on an ALU accept, clear on writeback (set wins).
// Ports: clk, reset (sync, active-high); wb_valid_i/wb_reg_i writeback;
// rd_i/rs1_i/rs2_i/is_alu_i incoming fields; set_i accept of an ALU op;
// hazard_o stall request; busy_o current bitmap.
module decode_scoreboard
  import decode_pkg::*;
#(
  parameter int NIB_WIDTH = NIB_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wb_valid_i,
  input  logic [NIB_WIDTH-1:0]    wb_reg_i,
  input  logic [NIB_WIDTH-1:0]    rd_i,
  input  logic [NIB_WIDTH-1:0]    rs1_i,
  input  logic [NIB_WIDTH-1:0]    rs2_i,
  input  logic                    is_alu_i,
  input  logic                    set_i,
  output logic                    hazard_o,
  output logic [2**NIB_WIDTH-1:0] busy_o
);

  localparam int R = 2**NIB_WIDTH;

  logic [R-1:0] busy_q, busy_d;
  logic [R-1:0] clr, eff;

  always_comb begin
    clr = '0;
    if (wb_valid_i) clr[wb_reg_i] = 1'b1;
  end

  // Same-cycle writeback already counts as retired for the stall check.
  assign eff = busy_q & ~clr;

  assign hazard_o = eff[rd_i]
                  | (is_alu_i & (eff[rs1_i] | eff[rs2_i]));

  always_comb begin
    busy_d = eff;
    if (set_i) busy_d[rd_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: splits instr into opcode/reg1/reg2/reg3 behind a one-deep
// valid/ready output register, with optional scoreboard stall.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/instr input
// side; out_valid/out_ready plus opcode, reg1..3, smallval, bigval,
// isaluop, aluop output side; wb_valid/wb_reg writeback; busy bitmap.
// Build option: DECODE_SCOREBOARD_EN enables the pending-write scoreboard;
// otherwise hazard and busy are tied to 0 and writeback is ignored.
module decode_stage
  import decode_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_W,
  parameter int NIB_WIDTH  = NIB_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_WIDTH-1:0]   instr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NIB_WIDTH-1:0]    opcode,
  output logic [NIB_WIDTH-1:0]    reg1,
  output logic [NIB_WIDTH-1:0]    reg2,
  output logic [NIB_WIDTH-1:0]    reg3,
  output logic [NIB_WIDTH-1:0]    smallval,
  output logic [2*NIB_WIDTH-1:0]  bigval,
  output logic                    isaluop,
  output logic [ALUOP_W-1:0]      aluop,
  input  logic                    wb_valid,
  input  logic [NIB_WIDTH-1:0]    wb_reg,
  output logic [2**NIB_WIDTH-1:0] busy
);

  localparam int N  = NIB_WIDTH;
  localparam int AF = alu_flag_bit(NIB_WIDTH);

  if (WORD_WIDTH != 4*NIB_WIDTH || NIB_WIDTH < ALUOP_W)
  begin : g_bad_cfg
    $error("decode_stage: need WORD_WIDTH == 4*NIB_WIDTH");
  end

  logic [N-1:0] f_op, f_r1, f_r2, f_r3;
  logic         f_alu;

  assign {f_op, f_r1, f_r2, f_r3} = instr;
  assign f_alu = !f_op[AF];

  logic         valid_q, valid_d;
  logic [N-1:0] op_q, op_d;
  logic [N-1:0] r1_q, r1_d;
  logic [N-1:0] r2_q, r2_d;
  logic [N-1:0] r3_q, r3_d;
  logic         alu_q, alu_d;
  logic         hazard;
  logic         acc;

  assign in_ready = (!valid_q || out_ready) && !hazard && !reset;
  assign acc      = in_valid && in_ready;

`ifdef DECODE_SCOREBOARD_EN
  decode_scoreboard #(
    .NIB_WIDTH (N)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .wb_valid_i (wb_valid),
    .wb_reg_i   (wb_reg),
    .rd_i       (f_r1),
    .rs1_i      (f_r2),
    .rs2_i      (f_r3),
    .is_alu_i   (f_alu),
    .set_i      (acc && f_alu),
    .hazard_o   (hazard),
    .busy_o     (busy)
  );
`else
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_reg};
  assign hazard    = 1'b0;
  assign busy      = '0;
`endif

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    r3_d    = r3_q;
    alu_d   = alu_q;
    if (acc) begin
      valid_d = 1'b1;
      op_d    = f_op;
      r1_d    = f_r1;
      r2_d    = f_r2;
      r3_d    = f_r3;
      alu_d   = f_alu;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      r3_q    <= '0;
      alu_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      r3_q    <= r3_d;
      alu_q   <= alu_d;
    end
  end

  assign out_valid = valid_q;
  assign opcode    = op_q;
  assign reg1      = r1_q;
  assign reg2      = r2_q;
  assign reg3      = r3_q;
  assign smallval  = r3_q;
  assign bigval    = {r2_q, r3_q};
  assign isaluop   = alu_q;
  assign aluop     = op_q[ALUOP_W-1:0];

endmodule
